// File: rtl/dram_req_queue_model.sv
// Cycle-accurate DRAM model: in-order request queue with a fixed access latency,
// per-byte write enables and a backpressured response channel (one response per request).
module dram_req_queue_model #(
    parameter string       ROMDATA = "",
    parameter int unsigned AWIDTH  = 10,
    parameter int unsigned SIZE    = 1024,
    parameter int unsigned DWIDTH  = 128,
    parameter int unsigned LATENCY = 8,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_WEN,
    input  logic [AWIDTH-1:0]   REQ_ADDR,
    input  logic [DWIDTH/8-1:0] REQ_BE,
    input  logic [DWIDTH-1:0]   REQ_DI,
    output logic                RESP_VALID,
    output logic                RESP_WEN,
    output logic [DWIDTH-1:0]   RESP_DOUT,
    input  logic                RESP_READY
);

    localparam int unsigned BW  = DWIDTH / 8;
    localparam int unsigned QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW  = QAW + 1;
    localparam int unsigned MAW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned LW  = 16;
    localparam logic [LW-1:0]     LAT_RELOAD = LW'(LATENCY - 2);
    localparam logic [AWIDTH:0]   SIZE_LIM   = (AWIDTH + 1)'(SIZE);
    localparam logic [CW-1:0]     FULL_COUNT = CW'(QDEPTH);

    typedef struct packed {
        logic              wen;
        logic [AWIDTH-1:0] addr;
        logic [BW-1:0]     be;
        logic [DWIDTH-1:0] di;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    req_t              q [QDEPTH];
    logic [DWIDTH-1:0] mem [SIZE];
    logic [QAW-1:0]    wr_ptr;
    logic [QAW-1:0]    rd_ptr;
    logic [CW-1:0]     count;
    logic [LW-1:0]     cnt;
    state_t            state;
    req_t              head;
    logic              push;
    logic              pop;
    logic              in_range;

    // Readiness follows occupancy only; a popping head never frees a slot early.
    assign REQ_READY = (count != FULL_COUNT) && !RST;
    assign push      = REQ_VALID && REQ_READY;
    assign pop       = (state == ACCESS);
    assign head      = q[rd_ptr];
    assign in_range  = {1'b0, head.addr} < SIZE_LIM;

    always_ff @(posedge CLK) begin
        if (push) begin
            q[wr_ptr] <= {REQ_WEN, REQ_ADDR, REQ_BE, REQ_DI};
        end
    end

    // Writes commit in ACCESS; reset drops a pending write.
    always_ff @(posedge CLK) begin
        if (!RST && pop && !head.wen && in_range) begin
            for (int unsigned i = 0; i < BW; i++) begin
                if (head.be[i]) begin
                    mem[MAW'(head.addr)][i*8 +: 8] <= head.di[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            RESP_VALID <= 1'b0;
            RESP_WEN   <= 1'b1;
            RESP_DOUT  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + QAW'(1);
            if (pop)  rd_ptr <= rd_ptr + QAW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            case (state)
                // An accept on this edge starts the countdown immediately.
                IDLE: begin
                    if (push || count != '0) begin
                        state <= WAIT;
                        cnt   <= LAT_RELOAD;
                    end
                end
                WAIT: begin
                    if (cnt != '0) cnt <= cnt - LW'(1);
                    else           state <= ACCESS;
                end
                ACCESS: begin
                    if (head.wen) begin
                        RESP_DOUT <= in_range ? mem[MAW'(head.addr)] : '0;
                    end
                    RESP_VALID <= 1'b1;
                    RESP_WEN   <= head.wen;
                    state      <= RESP;
                end
                RESP: begin
                    if (RESP_READY) begin
                        RESP_VALID <= 1'b0;
                        if (count != '0) begin
                            state <= WAIT;
                            cnt   <= LAT_RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_queue_model.sv
// Scoreboard bench for dram_req_queue_model: a LATENCY=8 instance for the main
// scenarios and a small LATENCY=2 instance for short-latency and range checks.
module tb_dram_req_queue_model;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_wen, resp_valid, resp_wen, resp_ready;
    logic [9:0]   req_addr;
    logic [15:0]  req_be;
    logic [127:0] req_di, resp_dout;

    logic         b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_wen, b_resp_ready;
    logic [9:0]   b_req_addr;
    logic [3:0]   b_req_be;
    logic [31:0]  b_req_di, b_resp_dout;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        logic         wen;
        logic [127:0] dout;
    } exp_t;

    exp_t         sb [$];
    logic [127:0] ref_mem [int];
    logic [127:0] last_rd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    dram_req_queue_model #(.AWIDTH(10), .SIZE(1024), .DWIDTH(128), .LATENCY(8), .QDEPTH(4)) dut (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WEN(req_wen),
        .REQ_ADDR(req_addr), .REQ_BE(req_be), .REQ_DI(req_di), .RESP_VALID(resp_valid),
        .RESP_WEN(resp_wen), .RESP_DOUT(resp_dout), .RESP_READY(resp_ready));

    dram_req_queue_model #(.AWIDTH(10), .SIZE(512), .DWIDTH(32), .LATENCY(2), .QDEPTH(2)) dut_b (
        .CLK(clk), .RST(rst), .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready), .REQ_WEN(b_req_wen),
        .REQ_ADDR(b_req_addr), .REQ_BE(b_req_be), .REQ_DI(b_req_di), .RESP_VALID(b_resp_valid),
        .RESP_WEN(b_resp_wen), .RESP_DOUT(b_resp_dout), .RESP_READY(b_resp_ready));

    // Drive one request at a negedge until accepted; optionally update model and scoreboard.
    task automatic send(input logic wen, input logic [9:0] addr, input logic [15:0] be,
                        input logic [127:0] di, input bit model, output int k);
        bit           got;
        exp_t         e;
        logic [127:0] cur;
        got = 0;
        k = -1;
        req_wen = wen; req_addr = addr; req_be = be; req_di = di; req_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            got = req_ready;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL send_accept addr=%h: req_ready never high, required accept", addr);
            return;
        end
        k = edge_cnt;
        if (model) begin
            cur = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
            if (!wen) begin
                for (int i = 0; i < 16; i++) if (be[i]) cur[i*8 +: 8] = di[i*8 +: 8];
                ref_mem[int'(addr)] = cur;
                e.wen = 1'b0; e.dout = last_rd;
            end else begin
                last_rd = cur;
                e.wen = 1'b1; e.dout = cur;
            end
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for a response, capture it, pop the expectation, step past the handshake edge.
    task automatic collect(output bit ok, output int at, output logic w, output logic [127:0] d,
                           output logic ew, output logic [127:0] ed);
        exp_t e;
        ok = 0; at = -1; w = 'x; d = 'x; ew = 'x; ed = 'x;
        for (int t = 0; t < 300 && !ok; t++) begin
            if (resp_valid) begin
                ok = 1; at = edge_cnt; w = resp_wen; d = resp_dout;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) begin
            if (sb.size() > 0) begin
                e = sb.pop_front(); ew = e.wen; ed = e.dout;
            end
            @(negedge clk);
        end
    endtask

    task automatic b_txn(input logic wen, input logic [9:0] addr, input logic [31:0] di,
                         output bit ok, output int k, output int at, output logic w, output logic [31:0] d);
        ok = 0; k = -1; at = -1; w = 'x; d = 'x;
        b_req_wen = wen; b_req_addr = addr; b_req_be = 4'hF; b_req_di = di; b_req_valid = 1'b1;
        for (int t = 0; t < 50 && k < 0; t++) begin
            if (b_req_ready) begin
                @(posedge clk); @(negedge clk); k = edge_cnt;
            end else begin
                @(negedge clk);
            end
        end
        b_req_valid = 1'b0;
        for (int t = 0; t < 50 && !ok && k >= 0; t++) begin
            if (b_resp_valid) begin
                ok = 1; at = edge_cnt; w = b_resp_wen; d = b_resp_dout;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_wen !== 1'b1) begin errors++; $display("FAIL rst_resp_wen got %b exp 1", resp_wen); end
        checks++; if (resp_dout !== '0) begin errors++; $display("FAIL rst_resp_dout got %h exp 0", resp_dout); end
        checks++; if (b_req_ready !== 1'b0) begin errors++; $display("FAIL rst_b_req_ready got %b exp 0", b_req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_req_ready got %b exp 1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        bit ok; int k, at; logic w, ew; logic [127:0] d, ed;
        resp_ready = 1'b1;
        send(1'b0, 10'h005, 16'hFFFF, {16{8'hAA}}, 1, k);
        collect(ok, at, w, d, ew, ed);
        checks++; if (!ok || w !== ew || d !== ed) begin errors++; $display("FAIL wr_resp got ok=%0b wen=%b dout=%h exp wen=%b dout=%h", ok, w, d, ew, ed); end
        send(1'b1, 10'h005, 16'h0000, '0, 1, k);
        collect(ok, at, w, d, ew, ed);
        checks++; if (!ok || w !== ew || d !== ed || d !== {16{8'hAA}}) begin errors++; $display("FAIL rd_resp got ok=%0b wen=%b dout=%h exp wen=%b dout=%h", ok, w, d, ew, ed); end
        checks++; if (at !== k + 8) begin errors++; $display("FAIL rd_latency got edge %0d exp edge %0d", at, k + 8); end
    endtask

    task automatic test_byte_enable();
        bit ok; int k, at; logic w, ew; logic [127:0] d, ed;
        resp_ready = 1'b1;
        send(1'b0, 10'h010, 16'hFFFF, '0, 1, k);
        send(1'b0, 10'h010, 16'h000F, {128{1'b1}}, 1, k);
        send(1'b1, 10'h010, 16'hFFFF, '0, 1, k);
        for (int i = 0; i < 3; i++) begin
            collect(ok, at, w, d, ew, ed);
            checks++; if (!ok || w !== ew || d !== ed) begin errors++; $display("FAIL be_resp%0d got ok=%0b wen=%b dout=%h exp wen=%b dout=%h", i, ok, w, d, ew, ed); end
        end
        checks++; if (d !== 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF) begin errors++; $display("FAIL be_low4 got %h exp low 4 bytes set", d); end
    endtask

    task automatic test_back_to_back_full();
        bit ok; int k, at; logic w, ew; logic [127:0] d, ed;
        resp_ready = 1'b0;
        send(1'b0, 10'h020, 16'hFFFF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1, k);
        send(1'b1, 10'h020, 16'h0000, '0, 1, k);
        send(1'b0, 10'h021, 16'hF0F0, 128'hCAFE_BABE_DEAD_BEEF_0123_4567_89AB_CDEF, 1, k);
        send(1'b1, 10'h021, 16'h0000, '0, 1, k);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", req_ready); end
        send(1'b1, 10'h020, 16'h0000, '0, 1, k);
        repeat (20) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_wen !== 1'b0) begin errors++; $display("FAIL stall_hold got valid=%b wen=%b exp valid=1 wen=0", resp_valid, resp_wen); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", req_ready); end
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            collect(ok, at, w, d, ew, ed);
            checks++; if (!ok || w !== ew || d !== ed) begin errors++; $display("FAIL full_resp%0d got ok=%0b wen=%b dout=%h exp wen=%b dout=%h", i, ok, w, d, ew, ed); end
        end
    endtask

    task automatic test_order_throughput();
        bit ok; int k, k0, at, prev; logic w, ew; logic [127:0] d, ed;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, 10'(10'h040 + i), 16'hFFFF, {32{4'(i + 5)}}, 1, k);
        for (int i = 0; i < 3; i++) collect(ok, at, w, d, ew, ed);
        send(1'b1, 10'h040, 16'h0000, '0, 1, k0);
        send(1'b1, 10'h041, 16'h0000, '0, 1, k);
        send(1'b1, 10'h042, 16'h0000, '0, 1, k);
        prev = k0 - 1;
        for (int i = 0; i < 3; i++) begin
            collect(ok, at, w, d, ew, ed);
            checks++; if (!ok || w !== ew || d !== ed) begin errors++; $display("FAIL order_resp%0d got ok=%0b wen=%b dout=%h exp wen=%b dout=%h", i, ok, w, d, ew, ed); end
            checks++;
            if ((i == 0 && at !== k0 + 8) || (i > 0 && at - prev !== 9)) begin
                errors++; $display("FAIL order_spacing%0d got edge %0d prev %0d (first accept %0d)", i, at, prev, k0);
            end
            prev = at;
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int k, at; logic w, ew; logic [127:0] d, ed;
        resp_ready = 1'b1;
        send(1'b0, 10'h030, 16'hFFFF, {8{16'h0BAD}}, 1, k);
        collect(ok, at, w, d, ew, ed);
        send(1'b0, 10'h030, 16'hFFFF, {8{16'h600D}}, 0, k);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midrst_state got valid=%b ready=%b exp 0 0", resp_valid, req_ready); end
        rst = 1'b0;
        sb.delete();
        last_rd = '0;
        send(1'b1, 10'h030, 16'h0000, '0, 1, k);
        collect(ok, at, w, d, ew, ed);
        checks++; if (!ok || w !== ew || d !== ed || d !== {8{16'h0BAD}}) begin errors++; $display("FAIL midrst_old got ok=%0b wen=%b dout=%h exp dout=%h", ok, w, d, ed); end
    endtask

    task automatic test_latency2();
        bit ok; int k, at; logic w; logic [31:0] d;
        b_resp_ready = 1'b1;
        b_txn(1'b0, 10'd3, 32'hDEAD_BEEF, ok, k, at, w, d);
        checks++; if (!ok || w !== 1'b0) begin errors++; $display("FAIL l2_wr got ok=%0b wen=%b exp wen=0", ok, w); end
        b_txn(1'b1, 10'd3, '0, ok, k, at, w, d);
        checks++; if (!ok || w !== 1'b1 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL l2_rd got ok=%0b wen=%b dout=%h exp deadbeef", ok, w, d); end
        checks++; if (at !== k + 2) begin errors++; $display("FAIL l2_latency got edge %0d exp edge %0d", at, k + 2); end
        b_txn(1'b0, 10'd512, 32'h1234_5678, ok, k, at, w, d);
        checks++; if (!ok || w !== 1'b0 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL l2_oor_wr got ok=%0b wen=%b dout=%h exp held deadbeef", ok, w, d); end
        b_txn(1'b1, 10'd512, '0, ok, k, at, w, d);
        checks++; if (!ok || w !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL l2_oor_rd got ok=%0b wen=%b dout=%h exp 0", ok, w, d); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b1; req_addr = '0; req_be = '0; req_di = '0; resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wen = 1'b1; b_req_addr = '0; b_req_be = '0; b_req_di = '0; b_resp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back_full();
        test_order_throughput();
        test_reset_mid();
        test_latency2();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
